// File: rtl/core_drain.sv
// core_drain: result drain for the dot-product core.
// Snapshots the full N_GROUP x N_UNIT accumulator bus on a capture pulse and
// streams it out one group row per beat over a valid/ready interface, so the
// core can start its next tile while the previous results are still draining.
// Optional feature macro: CORE_DRAIN_RELU_EN (clamps negative output words to 0
// on the output mux; the snapshot always keeps the raw values).
module core_drain #(
  parameter int N_GROUP = 4,
  parameter int N_UNIT  = 4,
  parameter int DW_ADD  = 32,
  localparam int DW_ROW      = DW_ADD * N_UNIT,
  localparam int DW_CORE_OUT = DW_ROW * N_GROUP,
  localparam int CW          = (N_GROUP > 1) ? $clog2(N_GROUP) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture,
  input  logic [DW_CORE_OUT-1:0] core_out,
  output logic                   capture_ready,
  output logic [DW_ROW-1:0]      out_data,
  output logic [CW-1:0]          out_row,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   overrun
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_ROW = CW'(N_GROUP - 1);

  state_t                              state_q;
  logic [CW-1:0]                       cnt_q;
  logic [N_GROUP-1:0][DW_ROW-1:0]      snap_q;
  logic                                overrun_q;

  logic handshake;
  logic accept;
  logic [DW_ROW-1:0] row_sel;

  // Handshake, back-to-back capture window and capture acceptance.
  always_comb begin
    out_valid     = (state_q == S_DRAIN);
    out_last      = out_valid && (cnt_q == LAST_ROW);
    out_row       = cnt_q;
    handshake     = out_valid && out_ready;
    capture_ready = (state_q == S_IDLE) || (handshake && out_last);
    accept        = capture && capture_ready;
  end

  // Output mux: select the current snapshot row, optionally clamping negatives.
  always_comb begin
    // NOTE: every output of a combinational block gets a default assignment
    // first, so no path leaves it unassigned and no latch is inferred.
    row_sel = snap_q[cnt_q];
`ifdef CORE_DRAIN_RELU_EN
    for (int u = 0; u < N_UNIT; u++) begin
      if (row_sel[(u+1)*DW_ADD-1]) begin
        row_sel[u*DW_ADD +: DW_ADD] = '0;
      end
    end
`endif
    out_data = row_sel;
  end

  // FSM: IDLE/DRAIN sequencing, row counter, snapshot capture and sticky overrun.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      // NOTE: the snapshot is wide storage but is still cleared on reset so
      // out_data reads as zero straight out of reset.
      snap_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture && !capture_ready) begin
        overrun_q <= 1'b1;
      end
      if (accept) begin
        snap_q  <= core_out;
        cnt_q   <= '0;
        state_q <= S_DRAIN;
      end else if (handshake) begin
        if (out_last) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_core_drain.sv
// Self-checking bench for core_drain (default parameters).
// Table of per-cycle vectors for the single-tile, backpressure, back-to-back,
// overrun and reset cases, plus a hand-written ReLU sequence.
module tb_core_drain;

  localparam int NG  = 4;
  localparam int NU  = 4;
  localparam int DW  = 32;
  localparam int ROW = DW * NU;
  localparam int BUS = ROW * NG;

  logic           clk = 1'b0;
  logic           reset;
  logic           capture;
  logic [BUS-1:0] core_out;
  logic           capture_ready;
  logic [ROW-1:0] out_data;
  logic [1:0]     out_row;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;
  logic           overrun;

  int n_checks = 0;
  int n_fail   = 0;

  core_drain dut (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .core_out     (core_out),
    .capture_ready(capture_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic cap;
    int   tile;
    logic rdy;
    logic e_v;
    int   e_row;
    logic e_last;
    logic e_cr;
    logic e_ovr;
    int   e_tile;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [ROW-1:0] act, input logic [ROW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tile 0: word(g,u)=16g+u. Tile 1: negative words. Tile 2: ReLU pattern in row 0.
  function automatic logic [DW-1:0] word(input int t, input int g, input int u);
    logic [DW-1:0] w;
    logic [DW-1:0] relu_words [4];
    relu_words[0] = 32'hFFFF_FFFB;
    relu_words[1] = 32'h0000_0007;
    relu_words[2] = 32'h8000_0000;
    relu_words[3] = 32'h0000_0000;
    case (t)
      0:       w = DW'(16 * g + u);
      1:       w = 32'hFFFF_FF00 + DW'(16 * g + u);
      default: w = (g == 0) ? relu_words[u] : '0;
    endcase
    return w;
  endfunction

  function automatic logic [BUS-1:0] tile_bus(input int t);
    logic [BUS-1:0] b;
    b = '0;
    for (int g = 0; g < NG; g++)
      for (int u = 0; u < NU; u++)
        b[(g*NU+u)*DW +: DW] = word(t, g, u);
    return b;
  endfunction

  function automatic logic [ROW-1:0] row_of(input int t, input int g);
    logic [ROW-1:0] r;
    logic [DW-1:0]  w;
    r = '0;
    for (int u = 0; u < NU; u++) begin
      w = word(t, g, u);
`ifdef CORE_DRAIN_RELU_EN
      if (w[DW-1]) w = '0;
`endif
      r[u*DW +: DW] = w;
    end
    return r;
  endfunction

  task automatic add(input logic rst, input logic cap, input int tile, input logic rdy,
                     input logic e_v, input int e_row, input logic e_last,
                     input logic e_cr, input logic e_ovr, input int e_tile);
    vec_t v;
    v.rst = rst; v.cap = cap; v.tile = tile; v.rdy = rdy;
    v.e_v = e_v; v.e_row = e_row; v.e_last = e_last;
    v.e_cr = e_cr; v.e_ovr = e_ovr; v.e_tile = e_tile;
    tbl.push_back(v);
  endtask

  initial begin
    logic [ROW-1:0] relu_exp;

    //  rst cap tile rdy | v  row last cr ovr etile
    // Single tile A, out_ready held high.
    add(0, 1, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,   1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1,   1, 2, 0, 0, 0, 0);
    add(0, 0, 0, 1,   1, 3, 1, 1, 0, 0);
    add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    // Backpressure on tile B.
    add(0, 1, 1, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1,   1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1,   1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0,   1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1,   1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0,   1, 3, 1, 0, 0, 1);
    // Back-to-back: capture A on B's last-row handshake.
    add(0, 1, 0, 1,   1, 3, 1, 1, 0, 1);
    add(0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    // Overrun: capture B during A row 1 is dropped.
    add(0, 1, 1, 1,   1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1,   1, 2, 0, 0, 1, 0);
    add(0, 0, 1, 1,   1, 3, 1, 1, 1, 0);
    add(0, 0, 1, 0,   0, 0, 0, 1, 1, 0);
    // Reset clears overrun.
    add(1, 0, 1, 0,   0, 0, 0, 1, 1, 0);
    // Reset mid-drain after the row-1 handshake.
    add(0, 1, 1, 1,   0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1,   1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1,   1, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0,   1, 2, 0, 0, 0, 1);
    add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1,   0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    // Reset beats a capture in the same cycle; overrun stays clear.
    add(1, 1, 1, 0,   1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0,   0, 0, 0, 1, 0, 0);

    reset = 1'b1; capture = 1'b0; core_out = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset out_valid", ROW'(out_valid), ROW'(1'b0));
    check("reset out_last", ROW'(out_last), ROW'(1'b0));
    check("reset out_row", ROW'(out_row), ROW'(0));
    check("reset capture_ready", ROW'(capture_ready), ROW'(1'b1));
    check("reset overrun", ROW'(overrun), ROW'(1'b0));
    check("reset out_data", out_data, '0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset     = tbl[i].rst;
      capture   = tbl[i].cap;
      core_out  = tile_bus(tbl[i].tile);
      out_ready = tbl[i].rdy;
      #1;
      check($sformatf("v%0d out_valid", i), ROW'(out_valid), ROW'(tbl[i].e_v));
      check($sformatf("v%0d capture_ready", i), ROW'(capture_ready), ROW'(tbl[i].e_cr));
      check($sformatf("v%0d overrun", i), ROW'(overrun), ROW'(tbl[i].e_ovr));
      check($sformatf("v%0d out_last", i), ROW'(out_last), ROW'(tbl[i].e_last));
      if (tbl[i].e_v) begin
        check($sformatf("v%0d out_row", i), ROW'(out_row), ROW'(tbl[i].e_row));
        check($sformatf("v%0d out_data", i), out_data, row_of(tbl[i].e_tile, tbl[i].e_row));
      end
    end

    // ReLU word pattern: -5, 7, 0x80000000, 0 in row 0.
    @(negedge clk);
    reset = 1'b0; capture = 1'b1; core_out = tile_bus(2); out_ready = 1'b0;
    @(negedge clk);
    capture = 1'b0; core_out = '0;
    #1;
`ifdef CORE_DRAIN_RELU_EN
    relu_exp = {32'h0000_0000, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000};
`else
    relu_exp = {32'h0000_0000, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFB};
`endif
    check("relu out_valid", ROW'(out_valid), ROW'(1'b1));
    check("relu row0 data", out_data, relu_exp);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("relu row1 row", ROW'(out_row), ROW'(1));
    check("relu row1 data", out_data, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
